// File: rtl/fetch_queue_ss.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue_ss
//  Purpose  : Dual-issue fetch stage. Owns the fetch PC, captures up to two
//             instruction words per cycle into a circular queue and presents
//             the two oldest entries to the decode pipes as slot 0 / slot 1.
//             Redirects flush the queue and reload the PC.
//  Options  : FETCHQ_STATS_EN adds stat_fetched / stat_flushes counters.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_queue_ss #(
  parameter int          DEPTH    = 8,
  parameter int          PTR_W    = 3,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata0,
  input  logic [31:0] imem_rdata1,
  input  logic        imem_ready,
  input  logic [1:0]  deq_req,
  input  logic        HZStall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        issue0_valid,
  output logic [31:0] issue0_instr,
  output logic [31:0] issue0_pc,
  output logic        issue1_valid,
  output logic [31:0] issue1_instr,
  output logic [31:0] issue1_pc,
`ifdef FETCHQ_STATS_EN
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushes,
`endif
  output logic        full,
  output logic        empty
);

  localparam logic [PTR_W:0] c_DEPTH = (PTR_W+1)'(DEPTH);

  // Queue storage: each entry holds {instr, pc}; contents need no reset.
  logic [31:0] r_instrMem [DEPTH];
  logic [31:0] r_pcMem    [DEPTH];

  logic [31:0]    r_pc;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic [1:0]       w_deqSat;
  logic [1:0]       w_nDeq;
  logic [1:0]       w_nPush;
  logic [PTR_W:0]   w_space;
  logic [PTR_W-1:0] w_head1;
  logic [PTR_W-1:0] w_tail1;

  assign w_head1   = r_head + PTR_W'(1);
  assign w_tail1   = r_tail + PTR_W'(1);
  assign w_space   = c_DEPTH - r_count;
  assign imem_addr = r_pc;
  assign full      = (r_count == c_DEPTH);
  assign empty     = (r_count == '0);

  // Effective dequeue: saturate the request at 2, clip to occupancy, and
  // suppress entirely on a hazard stall or a redirect.
  always_comb begin
    w_deqSat = (deq_req == 2'd3) ? 2'd2 : deq_req;
    w_nDeq   = 2'd0;
    if (!HZStall && !redirect_valid) begin
      if ((PTR_W+1)'(w_deqSat) > r_count) begin
        w_nDeq = r_count[1:0];
      end else begin
        w_nDeq = w_deqSat;
      end
    end
  end

  // Push count uses occupancy before this cycle's dequeue, so space freed
  // by a same-cycle dequeue is never reused. An odd-word PC pushes only one
  // word so the PC realigns to an even word for later dual fetches.
  always_comb begin
    w_nPush = 2'd2;
    if (reset || redirect_valid || !imem_ready || (w_space == '0)) begin
      w_nPush = 2'd0;
    end else if (r_pc[2] || (w_space == (PTR_W+1)'(1))) begin
      w_nPush = 2'd1;
    end
  end

  // Issue slots are combinational views of the two oldest entries.
  always_comb begin
    issue0_valid = (r_count >= (PTR_W+1)'(1));
    issue1_valid = (r_count >= (PTR_W+1)'(2));
    issue0_instr = issue0_valid ? r_instrMem[r_head]  : 32'h0;
    issue0_pc    = issue0_valid ? r_pcMem[r_head]     : 32'h0;
    issue1_instr = issue1_valid ? r_instrMem[w_head1] : 32'h0;
    issue1_pc    = issue1_valid ? r_pcMem[w_head1]    : 32'h0;
  end

  // Storage write: word at pc to tail, word at pc+4 to tail+1.
  always_ff @(posedge clk) begin
    if (w_nPush != 2'd0) begin
      r_instrMem[r_tail] <= imem_rdata0;
      r_pcMem[r_tail]    <= r_pc;
    end
    if (w_nPush == 2'd2) begin
      r_instrMem[w_tail1] <= imem_rdata1;
      r_pcMem[w_tail1]    <= r_pc + 32'd4;
    end
  end

  // Pointer, occupancy and fetch PC update; reset beats redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= {RESET_PC[31:2], 2'b00};
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (redirect_valid) begin
      r_pc    <= {redirect_pc[31:2], 2'b00};
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_pc    <= r_pc + 32'({w_nPush, 2'b00});
      r_head  <= r_head + PTR_W'(w_nDeq);
      r_tail  <= r_tail + PTR_W'(w_nPush);
      r_count <= r_count + (PTR_W+1)'(w_nPush) - (PTR_W+1)'(w_nDeq);
    end
  end

`ifdef FETCHQ_STATS_EN
  logic [31:0] r_statFetched;
  logic [31:0] r_statFlushes;

  // Statistics: words pushed and redirect cycles, both wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_statFetched <= 32'h0;
      r_statFlushes <= 32'h0;
    end else begin
      r_statFetched <= r_statFetched + 32'(w_nPush);
      if (redirect_valid) begin
        r_statFlushes <= r_statFlushes + 32'd1;
      end
    end
  end

  assign stat_fetched = r_statFetched;
  assign stat_flushes = r_statFlushes;
`endif

endmodule
`default_nettype wire

// File: doc/fetch_queue_ss.md
Name: fetch_queue_ss

Overview:
- Superscalar fetch stage that sits directly upstream of the two decode pipes.
- Owns the fetch PC and drives the instruction memory address. Captures up to two instruction words per cycle into a circular queue.
- Presents the two oldest entries to the issue logic as slot 0 (older) and slot 1 (younger). Each slot feeds the InstrF/PCF inputs of one pipe.
- Redirects (taken branch, jump, misprediction fix) flush the queue and reload the PC.

Parameters:
- DEPTH, 8, number of queue entries; power of two, minimum 4.
- PTR_W, 3, pointer width, equal to log2(DEPTH).
- RESET_PC, 32'h0, fetch PC loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  32  current fetch PC, always word aligned (bits [1:0] = 0).
- imem_rdata0  in  32  instruction at imem_addr, combinational from memory.
- imem_rdata1  in  32  instruction at imem_addr+4.
- imem_ready  in  1  memory data valid this cycle; low means a cache stall.
- deq_req  in  2  number of slots the issue logic consumes this cycle; 0, 1 or 2, and 3 is treated as 2.
- HZStall  in  1  hazard stall; forces the effective dequeue count to 0.
- redirect_valid  in  1  flush the queue and load redirect_pc.
- redirect_pc  in  32  new fetch PC; bits [1:0] are ignored (forced 0).
- issue0_valid  out  1  slot 0 holds a valid entry.
- issue0_instr  out  32  slot 0 instruction; 0 (nop) when invalid.
- issue0_pc  out  32  slot 0 PC; 0 when invalid.
- issue1_valid  out  1  slot 1 holds a valid entry.
- issue1_instr  out  32  slot 1 instruction; 0 when invalid.
- issue1_pc  out  32  slot 1 PC; 0 when invalid.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (synchronous, active-high):
  - pc = RESET_PC; head, tail and count = 0.
  - Storage contents are don't-care.
  - After the reset edge: all valid outputs 0, instr/pc outputs 0, empty = 1, full = 0.
- Issue outputs are combinational from head and count:
  - issue0 shows entry[head] and is valid when count >= 1.
  - issue1 shows entry[head+1 mod DEPTH] and is valid when count >= 2.
- Effective dequeue: n_deq = 0 if HZStall or redirect_valid; otherwise min(deq_req sat 2, count). A request beyond count is clipped, not an error.
- Push count n_push:
  - space = DEPTH - count, using count before this cycle's dequeue.
  - n_push = 0 when any of: reset, redirect_valid, !imem_ready, space == 0.
  - n_push = 1 when pc[2] == 1 (odd word; only the word at pc is pushed) or when space == 1.
  - n_push = 2 otherwise.
- Push order: the word at pc goes to entry[tail]; the word at pc+4 goes to entry[tail+1]. Each entry stores {instr, pc}.
- Register update each edge:
  - tail += n_push; head += n_deq; both wrap mod DEPTH.
  - count = count + n_push - n_deq. Range 0..DEPTH, never overflows or underflows.
  - pc += 4 * n_push.
- Push and dequeue in the same cycle are legal, including at full and at empty:
  - At full, the push is blocked even if a dequeue frees space that cycle (no same-cycle space reuse).
  - At empty, the dequeue is clipped to 0; a pushed word is first visible on the next cycle. Fetch-to-issue latency is 1 cycle minimum.
- Redirect has priority over all but reset:
  - Next edge: head, tail and count = 0; pc = {redirect_pc[31:2], 2'b00}.
  - Any imem data that cycle is discarded.
  - Issue outputs still show the old contents during the redirect cycle, but no dequeue is counted.
- imem_ready low: pc holds, nothing is pushed; dequeue continues normally.
- reset and redirect_valid together: reset wins, pc = RESET_PC.

Optional Feature:
- Macro: FETCHQ_STATS_EN.
- When defined, two extra outputs are added:
  - stat_fetched (32 out): counts entries pushed (+n_push per cycle).
  - stat_flushes (32 out): counts cycles with redirect_valid = 1 (excluding reset).
- Both counters are cleared by reset and wrap at 2^32.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then imem_ready = 1, deq_req = 0 for 4 cycles (RESET_PC = 0): count 2, 4, 6, 8; full = 1 after cycle 4. Entries hold pc 0, 4, 8, ..., 0x1C; imem_addr stays 0x20 once full.
- Full queue, deq_req = 2, imem_ready = 1 for 1 cycle: push blocked, count 8 -> 6. Issue slots were pc 0x0 and 0x4; next cycle they show 0x8 and 0xC.
- Empty queue, redirect_pc = 0x44, then imem_ready = 1: first push is 1 word (pc 0x44, odd word); next cycle pushes 0x48 and 0x4C; count 1 then 3.
- Queue at count 5, redirect_valid = 1 with deq_req = 2: next cycle count = 0, empty = 1, issue0_valid = 0, issue0_instr = 0, imem_addr = redirect_pc.
- count = 1, deq_req = 2, HZStall = 0: only 1 dequeued, count = 0. Repeat with HZStall = 1: count is unchanged.
- Wrap-around: 20 cycles with push 2 and deq 2 in steady state. Issued PCs are strictly sequential (+4 each) with no gaps or duplicates across the head/tail wrap.
